// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MD operation class encoding
// (also used by the decoder) and the MDU state enum.
package mdu_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    function automatic logic is_md_arith(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic logic is_md_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic core: full-width product, or {remainder, quotient}
// for divides, selected by the MD operation class.
module mdu_calc
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         op,
    output logic [2*WIDTH-1:0] result,
    output logic               div_zero
);

    logic               is_signed;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] product;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   den;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign is_signed = (op == MD_MULT) || (op == MD_DIV);

    // Low 2W bits of the product of sign-extended operands equal the signed product.
    assign a_ext   = is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign b_ext   = is_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign product = a_ext * b_ext;

    assign a_neg    = is_signed & a[WIDTH-1];
    assign b_neg    = is_signed & b[WIDTH-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign div_zero = (b == '0);

    // MIN magnitude stays 0x80..0 as unsigned, so MIN/-1 naturally yields MIN, rem 0.
    assign den   = div_zero ? WIDTH'(1) : b_mag;
    assign q_mag = a_mag / den;
    assign r_mag = a_mag % den;
    assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    assign rem   = a_neg ? -r_mag : r_mag;

    assign result = is_md_div(op) ? {rem, quot} : product;

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: owns HI/LO, runs mult/div with a fixed countdown latency,
// serves mthi/mtlo writes and mfhi/mflo reads; busy is the pipeline stall source.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
    logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
    logic               pend_skip_q, pend_skip_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] calc_result;
    logic               calc_div_zero;

    mdu_calc #(.WIDTH(WIDTH)) u_calc (
        .a        (a),
        .b        (b),
        .op       (op),
        .result   (calc_result),
        .div_zero (calc_div_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= MD_IDLE;
            cnt_q       <= '0;
            pend_hi_q   <= '0;
            pend_lo_q   <= '0;
            pend_skip_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_skip_q <= pend_skip_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_skip_d = pend_skip_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (start && !flush) begin
                    if (is_md_arith(op)) begin
                        state_d     = MD_BUSY;
                        cnt_d       = is_md_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        pend_hi_d   = calc_result[2*WIDTH-1:WIDTH];
                        pend_lo_d   = calc_result[WIDTH-1:0];
                        pend_skip_d = is_md_div(op) && calc_div_zero;
                    end else if (op == MD_MTHI) begin
                        hi_d = a;
                    end else if (op == MD_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            MD_BUSY: begin
                if (flush) begin
                    state_d     = MD_IDLE;
                    cnt_d       = '0;
                    pend_hi_d   = '0;
                    pend_lo_d   = '0;
                    pend_skip_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = MD_IDLE;
                        if (!pend_skip_q) begin
                            hi_d = pend_hi_q;
                            lo_d = pend_lo_q;
                        end
                    end
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        rdata = '0;
        if (op == MD_MFHI)      rdata = hi_q;
        else if (op == MD_MFLO) rdata = lo_q;
    end

    assign busy = (state_q == MD_BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: vector table for arithmetic and HI/LO moves, plus
// hand-written sequences for busy-ignore, flush, reset and single-cycle latency.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, flush;
    logic [3:0]  op;
    logic [31:0] a, b;
    logic        busy, f_busy;
    logic [31:0] hi, lo, rdata, f_hi, f_lo, f_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo), .rdata(rdata)
    );

    mdu #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut_fast (
        .clk(clk), .reset(reset), .start(start), .flush(flush), .op(op),
        .a(a), .b(b), .busy(f_busy), .hi(f_hi), .lo(f_lo), .rdata(f_rdata)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb);
        @(negedge clk);
        start = 1'b1; op = o; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0; op = MD_NONE;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int cyc;

        vt[0]  = '{MD_MULT,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        vt[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 5};
        vt[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vt[3]  = '{MD_DIVU,  32'h7,        32'h2,        32'h1,        32'h3,        10};
        vt[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10};
        vt[5]  = '{MD_MULT,  32'hFFFFFFFD, 32'hFFFFFFFB, 32'h0,        32'hF,        5};
        vt[6]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vt[7]  = '{MD_DIV,   32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 10};
        vt[8]  = '{MD_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h2,        10};
        vt[9]  = '{MD_MTHI,  32'h11,       32'h0,        32'h11,       32'h2,        0};
        vt[10] = '{MD_MTLO,  32'h22,       32'h0,        32'h11,       32'h22,       0};
        vt[11] = '{MD_DIV,   32'h5,        32'h0,        32'h11,       32'h22,       10};
        vt[12] = '{MD_DIVU,  32'hFFFFFFFF, 32'h0,        32'h11,       32'h22,       10};
        vt[13] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        5};

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = MD_NONE; a = '0; b = '0;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_rdata", rdata, 0);
        @(negedge clk) reset = 1'b0;

        // Single-cycle latency instance alongside the default one.
        issue(MD_MULT, 32'd3, 32'd5);
        chk("n1_busy_edge0", f_busy, 1);
        chk("main_busy_edge0", busy, 1);
        @(posedge clk); #1;
        chk("n1_busy_edge1", f_busy, 0);
        chk("n1_lo_edge1", f_lo, 32'd15);
        chk("main_lo_edge1", lo, 0);
        wait_idle(cyc);
        chk("main_3x5_lo", lo, 32'd15);

        for (int i = 0; i < 14; i++) begin
            issue(vt[i].op, vt[i].a, vt[i].b);
            wait_idle(cyc);
            chk($sformatf("v%0d_cycles", i), cyc, vt[i].cyc);
            chk($sformatf("v%0d_hi", i), hi, vt[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vt[i].lo);
            chk($sformatf("v%0d_rdata_none", i), rdata, 0);
            op = MD_MFHI; #1;
            chk($sformatf("v%0d_mfhi", i), rdata, vt[i].hi);
            op = MD_MFLO; #1;
            chk($sformatf("v%0d_mflo", i), rdata, vt[i].lo);
            op = MD_NONE;
            chk($sformatf("v%0d_fast_hi", i), f_hi, vt[i].hi);
            chk($sformatf("v%0d_fast_lo", i), f_lo, vt[i].lo);
        end

        // Requests while busy are ignored.
        issue(MD_MULT, 32'hFFFFFFFF, 32'h2);
        @(negedge clk); start = 1'b1; op = MD_MTHI; a = 32'hDEAD;
        @(posedge clk); #1; start = 1'b0; op = MD_NONE;
        @(negedge clk); start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd7;
        @(posedge clk); #1; start = 1'b0; op = MD_NONE;
        wait_idle(cyc);
        chk("ign_cycles", cyc + 2, 5);
        chk("ign_hi", hi, 32'hFFFFFFFF);
        chk("ign_lo", lo, 32'hFFFFFFFE);
        for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
        chk("ign_busy_after", busy, 0);

        // Flush in cycle 3 of a multiply.
        issue(MD_MULTU, 32'd3, 32'd4);
        for (int k = 0; k < 2; k++) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_hi", hi, 32'hFFFFFFFF);
        chk("flush_lo", lo, 32'hFFFFFFFE);
        for (int k = 0; k < 8; k++) begin @(posedge clk); #1; end
        chk("flush_late_lo", lo, 32'hFFFFFFFE);

        // Flush on the commit cycle wins.
        issue(MD_MULTU, 32'd3, 32'd4);
        for (int k = 0; k < 4; k++) begin @(posedge clk); #1; end
        chk("flushc_busy_before", busy, 1);
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flushc_busy", busy, 0);
        chk("flushc_lo", lo, 32'hFFFFFFFE);

        // Flush drops a same-cycle mtlo; a plain mtlo afterwards lands.
        @(negedge clk); start = 1'b1; op = MD_MTLO; a = 32'h55; flush = 1'b1;
        @(posedge clk); #1; start = 1'b0; op = MD_NONE; flush = 1'b0;
        chk("flush_mtlo_lo", lo, 32'hFFFFFFFE);
        chk("flush_mtlo_busy", busy, 0);
        issue(MD_MTLO, 32'h55, 32'h0);
        op = MD_MFLO; #1;
        chk("mtlo_then_mflo", rdata, 32'h55);
        op = MD_NONE;

        // Asynchronous reset in cycle 4 of a divide.
        issue(MD_DIV, 32'd100, 32'd7);
        for (int k = 0; k < 3; k++) begin @(posedge clk); #1; end
        chk("rst_busy_before", busy, 1);
        reset = 1'b1; #1;
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        @(negedge clk); reset = 1'b0; op = MD_MFHI; #1;
        chk("rst_mfhi", rdata, 0);
        op = MD_NONE;
        issue(MD_MULT, 32'd6, 32'd7);
        wait_idle(cyc);
        chk("post_rst_cycles", cyc, 5);
        chk("post_rst_hi", hi, 0);
        chk("post_rst_lo", lo, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the pipelined MIPS core: executes `mult`/`multu`/`div`/`divu` over a parametrised operand width with a configurable multi-cycle latency, owns the HI/LO registers, and serves `mthi`/`mtlo`/`mfhi`/`mflo`. It sits beside the ALU in the EX stage and is driven by the decoder's 4-bit MD operation class. `busy` is the stall source for the hazard unit. A `flush` input aborts an in-flight operation for exception handling.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: multiply latency in cycles, ≥1.
- `DIV_CYCLES`, 10: divide latency in cycles, ≥1.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: qualifies `op` for ops 1–4, 7, 8.
- `flush` in 1: abort the in-flight operation.
- `op` in 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
- `a` in WIDTH: rs operand, dividend / multiplicand / mthi-mtlo data.
- `b` in WIDTH: rt operand, divisor / multiplier.
- `busy` out 1: operation in flight.
- `hi` out WIDTH: committed HI.
- `lo` out WIDTH: committed LO.
- `rdata` out WIDTH: combinational read; `hi` if op=5, `lo` if op=6, else 0.

## Operation
- Reset values: `hi`=0, `lo`=0, `busy`=0, counter=0, pending registers=0.
- FSM has two states:
  - IDLE → BUSY when `start` and op∈{1..4}. Operands are latched, the result is computed into pending HI/LO, and the counter loads `MULT_CYCLES` or `DIV_CYCLES`.
  - BUSY: the counter decrements each edge. On the edge where counter==1, pending is written to `hi`/`lo` and the FSM returns to IDLE.
- Multiply: {HI,LO} = full 2·WIDTH product. Signed for op 1, unsigned for op 2.
- Divide: LO = quotient, HI = remainder.
  - Signed (op 3): quotient truncates toward zero; the remainder takes the sign of the dividend.
  - MIN/−1: LO = MIN, HI = 0.
- Divisor 0: the full latency still runs, but `hi`/`lo` are left unchanged at commit.
- mthi/mtlo: with `start`, op 7/8, and IDLE, `a` is written to `hi`/`lo` on the next edge. `busy` stays 0.
- `start` while BUSY is ignored for every op. The hazard unit must stall, so this case is not an error.
- `flush`:
  - In BUSY, the next edge returns the FSM to IDLE, clears the counter, and discards pending; `hi`/`lo` are unchanged.
  - `flush` has priority over a same-cycle `start`: the `start` is dropped, including mthi/mtlo.
  - `flush` arriving on the commit cycle wins: no commit.
- mfhi/mflo are pure combinational reads of the committed values. They do not depend on `start` or `busy`; the stall covers ordering.
- Asynchronous `reset` mid-operation forces all state to reset values immediately.

## Timing
- `start` sampled at edge 0 → `busy`=1 after edges 0..N−1, with N = latency.
- Edge N: `hi`/`lo` update and `busy`=0.
- A new `start` is accepted in the cycle after `busy` falls.
- With N=1: `busy` is high for one cycle and the commit happens at edge 1.
- mthi/mtlo: a one-edge write. A `mfhi` in the following cycle sees the new value.
- `rdata` has zero latency from `op`/`hi`/`lo`.

## Structure
- Shared package `mdu_pkg` holds:
  - the op encoding constants (`MD_NONE`..`MD_MTLO`), shared with the decoder's `alu_class`;
  - the state enum `{MD_IDLE, MD_BUSY}`.
- Sub-module `mdu_calc`: combinational; takes `a`, `b`, `op`, `WIDTH` and produces the 2·WIDTH product or quotient/remainder plus a `div_zero` flag.
- The top level holds the FSM, counter, pending registers and HI/LO.

## Test plan
Defaults: WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10.
1. **Multiply, signed vs unsigned.**
   - mult a=0xFFFFFFFF, b=2 → `busy` high 5 cycles; at edge 5 HI=0xFFFFFFFF, LO=0xFFFFFFFE.
   - multu with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
2. **Divide, signed vs unsigned.**
   - div a=0xFFFFFFF9 (−7), b=2 → at edge 10 LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - divu 7/2 → LO=3, HI=1.
   - div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
3. **Divide by zero.** Preload HI=0x11, LO=0x22 via mthi/mtlo, then div by 0 → `busy` for 10 cycles, HI/LO stay 0x11/0x22.
4. **Requests while busy.** During an in-flight mult, `start` with mthi and with divu are both ignored. Final HI/LO equal the mult result, and `busy` falls at edge 5.
5. **Flush.** Assert `flush` in cycle 3 of a mult → `busy`=0 after the next edge and HI/LO keep their old values. `flush` together with mtlo `start` → LO unchanged.
6. **Reset mid-operation.** Assert `reset` in cycle 4 of a div → `busy`, `hi`, `lo` are 0 immediately. After deassert, mfhi gives `rdata`=0 and a new mult completes normally.
